uart_tx_arbiter: RTL and testbench

//  Shares one UART byte transmitter between N_REQ requesters. Round-robin arbitration; grant held for a

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin sharing of one UART byte serializer between N_REQ message sources.
// Latency : req_valid in IDLE -> grant/req_ready next cycle -> tx_start the cycle after; tx_done -> tx_start in 2.
// Backpressure: req_ready only on the granted lane while in SEND; one byte outstanding at the serializer at a time.
//
// Ports:
//   clk_fpga, rst_n          clock, synchronous active-low reset
//   req_valid/req_data/req_last/req_ready   per-lane byte stream (lane i = byte [8i+7:8i])
//   grant                    one-hot owner, zero when idle
//   tx_data/tx_start/tx_done serializer handshake (tx_start 1-cycle load pulse, tx_done stop-bit pulse)
//   busy                     high whenever not IDLE
//   err                      1-cycle pulse when the watchdog abandons a byte
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk_fpga,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               busy,
  output logic               err
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             tx_start_q, tx_start_d;
  logic             err_q, err_d;
  logic             last_q, last_d;

  // Round-robin pick: the valid lane with the smallest forward distance from rr_ptr wins.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  int               best_d, cand_d;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    best_d     = N_REQ;
    cand_d     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_d = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q)) : (i + N_REQ - int'(rr_ptr_q));
      if (req_valid[i] && (cand_d < best_d)) begin
        best_d     = cand_d;
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  // Views of the granted lane; grant_q is one-hot so AND-OR selection is exact.
  logic             g_valid, g_last;
  logic [7:0]       g_data;
  logic [IDX_W-1:0] g_next;

  assign g_valid = |(req_valid & grant_q);
  assign g_last  = |(req_last & grant_q);
  assign g_next  = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) g_data = g_data | req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    burst_cnt_d = burst_cnt_q;
    wdog_d      = wdog_q;
    last_d      = last_q;
    tx_start_d  = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = N_REQ'(1) << pick_idx;
          gidx_d      = pick_idx;
          burst_cnt_d = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (g_valid) begin
          tx_data_d   = g_data;
          tx_start_d  = 1'b1;
          last_d      = g_last;
          burst_cnt_d = burst_cnt_q + 8'd1;
          wdog_d      = '0;
          state_d     = WAIT;
        end else begin
          // Requester dropped its stream: hand the serializer on.
          grant_d  = '0;
          rr_ptr_d = g_next;
          state_d  = IDLE;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        // tx_done coinciding with our own tx_start cannot belong to this byte.
        if (tx_done && !tx_start_q) begin
          if (last_q || (burst_cnt_q == 8'(MAX_BURST))) begin
            grant_d  = '0;
            rr_ptr_d = g_next;
            state_d  = IDLE;
          end else begin
            state_d = SEND;
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = g_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      tx_data_q   <= '0;
      burst_cnt_q <= '0;
      wdog_q      <= '0;
      tx_start_q  <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      burst_cnt_q <= burst_cnt_d;
      wdog_q      <= wdog_d;
      tx_start_q  <= tx_start_d;
      err_q       <= err_d;
      last_q      <= last_d;
    end
  end

  assign req_ready = grant_q & {N_REQ{state_q == SEND}};
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 64;

  logic           clk_fpga = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done;
  logic           busy;
  logic           err;

  always #5 clk_fpga = ~clk_fpga;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk_fpga (clk_fpga),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy),
    .err      (err)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [7:0]   data;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [31:0]  data;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_byte;
  } vec_t;

  exp_t       sb_q[$];
  logic [8:0] src_q[N][$];   // {last, byte} per requester lane
  int         start_cyc_q[$];
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0, n_starts = 0, n_err = 0, last_err_cyc = -1;
  int         done_at = -1, done_dly = 0;
  bit         auto_done = 1'b0, clear_on_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_lanes();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        e = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: handshake sampled before the edge, outputs observed 1 time unit after it.
  task automatic step();
    logic [N-1:0] hs;
    logic [8:0]   tmp;
    exp_t         e;
    hs = req_valid & req_ready;
    @(posedge clk_fpga);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && src_q[i].size() != 0) tmp = src_q[i].pop_front();
    end
    check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    if (tx_start) begin
      n_starts++;
      start_cyc_q.push_back(cyc);
      check("tx_start_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("tx_grant", {28'd0, grant}, {28'd0, e.grant});
        check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
      end
      if (auto_done) done_at = cyc + done_dly;
      if (clear_on_start) begin
        for (int i = 0; i < N; i++) src_q[i].delete();
      end
    end
    if (err) begin
      n_err++;
      last_err_cyc = cyc;
    end
    tx_done = auto_done && (cyc == done_at);
    drive_lanes();
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < N; i++) src_q[i].delete();
    sb_q.delete();
    rst_n   = 1'b0;
    tx_done = 1'b0;
    drive_lanes();
    repeat (ncyc) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n;
    bit pend;
    n = 0;
    do begin
      step();
      n++;
      pend = busy || (sb_q.size() != 0) || (|req_valid);
    end while (pend && n < budget);
    check(name, {31'd0, pend}, 32'd0);
  endtask

  task automatic wait_start(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_start && n < budget);
    check(name, {31'd0, tx_start}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int k, s, st, er;
    bit g_ok;

    vecs[0] = '{4'b0001, 32'h13121110, 4'b0001, 8'h10};
    vecs[1] = '{4'b0001, 32'h23222120, 4'b0001, 8'h20};
    vecs[2] = '{4'b1111, 32'h33323130, 4'b0010, 8'h31};
    vecs[3] = '{4'b0011, 32'h43424140, 4'b0001, 8'h40};
    vecs[4] = '{4'b1100, 32'h53525150, 4'b0100, 8'h52};
    vecs[5] = '{4'b1011, 32'h63626160, 4'b1000, 8'h63};
    vecs[6] = '{4'b0110, 32'h73727170, 4'b0010, 8'h71};
    vecs[7] = '{4'b1001, 32'h83828180, 4'b1000, 8'h83};

    rst_n     = 1'b0;
    tx_done   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    do_reset(2);

    // Reset state
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Table: single-byte messages from IDLE; losers withdraw once the winner's byte starts.
    auto_done      = 1'b1;
    done_dly       = 4;
    clear_on_start = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        if (vecs[r].mask[i]) src_q[i].push_back({1'b1, vecs[r].data[8*i +: 8]});
      end
      sb_q.push_back({vecs[r].exp_grant, vecs[r].exp_byte});
      drive_lanes();
      step();
      check("vec_grant", {28'd0, grant}, {28'd0, vecs[r].exp_grant});
      check("vec_ready", {28'd0, req_ready}, {28'd0, vecs[r].exp_grant});
      step();
      check("vec_tx_start", {31'd0, tx_start}, 32'd1);
      wait_quiet(40, "vec_release");
      check("vec_busy_after", {31'd0, busy}, 32'd0);
    end
    clear_on_start = 1'b0;

    // 1: one requester, three-byte message, tx_done 20 cycles after each start
    done_dly = 20;
    start_cyc_q.delete();
    src_q[0].push_back({1'b0, 8'h55});
    src_q[0].push_back({1'b0, 8'hA3});
    src_q[0].push_back({1'b1, 8'h0F});
    sb_q.push_back({4'b0001, 8'h55});
    sb_q.push_back({4'b0001, 8'hA3});
    sb_q.push_back({4'b0001, 8'h0F});
    drive_lanes();
    k    = cyc;
    g_ok = 1'b1;
    s    = 0;
    do begin
      step();
      s++;
      if (busy && grant != 4'b0001) g_ok = 1'b0;
    end while ((busy || (|req_valid) || sb_q.size() != 0) && s < 200);
    check("t1_grant_held", {31'd0, g_ok}, 32'd1);
    check("t1_start_count", start_cyc_q.size(), 32'd3);
    if (start_cyc_q.size() == 3) begin
      check("t1_first_latency", start_cyc_q[0] - k, 32'd2);
      check("t1_b2b_gap1", start_cyc_q[1] - start_cyc_q[0], 32'd22);
      check("t1_b2b_gap2", start_cyc_q[2] - start_cyc_q[1], 32'd22);
    end
    check("t1_release_cycle", cyc, done_at + 1);
    check("t1_busy_low", {31'd0, busy}, 32'd0);

    // 2: all lanes with one-byte messages, lane 0 has two -> full rotation
    do_reset(2);
    done_dly = 3;
    st = n_starts;
    src_q[0].push_back({1'b1, 8'h00});
    src_q[0].push_back({1'b1, 8'h01});
    src_q[1].push_back({1'b1, 8'h10});
    src_q[2].push_back({1'b1, 8'h20});
    src_q[3].push_back({1'b1, 8'h30});
    sb_q.push_back({4'b0001, 8'h00});
    sb_q.push_back({4'b0010, 8'h10});
    sb_q.push_back({4'b0100, 8'h20});
    sb_q.push_back({4'b1000, 8'h30});
    sb_q.push_back({4'b0001, 8'h01});
    drive_lanes();
    wait_quiet(200, "t2_complete");
    check("t2_start_count", n_starts - st, 32'd5);

    // 3: 40-byte stream on lane 1 without last, lane 2 waiting -> burst cap forces rotation
    done_dly = 2;
    st = n_starts;
    for (int j = 0; j < 40; j++) src_q[1].push_back({1'b0, 8'h80 + 8'(j)});
    src_q[2].push_back({1'b1, 8'hEE});
    for (int j = 0; j < 16; j++) sb_q.push_back({4'b0010, 8'h80 + 8'(j)});
    sb_q.push_back({4'b0100, 8'hEE});
    for (int j = 16; j < 40; j++) sb_q.push_back({4'b0010, 8'h80 + 8'(j)});
    drive_lanes();
    wait_quiet(1000, "t3_complete");
    check("t3_start_count", n_starts - st, 32'd41);

    // 4: tx_done never arrives -> watchdog abort exactly TIMEOUT cycles after WAIT entry
    auto_done = 1'b0;
    er = n_err;
    src_q[3].push_back({1'b1, 8'h5A});
    sb_q.push_back({4'b1000, 8'h5A});
    drive_lanes();
    wait_start(10, "t4_start_seen");
    s = cyc;
    k = 0;
    do begin
      step();
      k++;
    end while (!err && k < 200);
    check("t4_err_seen", {31'd0, err}, 32'd1);
    check("t4_err_delay", cyc - s, 32'd64);
    check("t4_grant_released", {28'd0, grant}, 32'd0);
    check("t4_busy_low", {31'd0, busy}, 32'd0);
    step();
    check("t4_err_pulse_width", {31'd0, err}, 32'd0);
    check("t4_err_count", n_err - er, 32'd1);

    // 5: reset asserted for 2 cycles in WAIT
    src_q[2].push_back({1'b1, 8'hC6});
    sb_q.push_back({4'b0100, 8'hC6});
    drive_lanes();
    wait_start(10, "t5_start_seen");
    repeat (3) step();
    check("t5_busy_pre_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive_lanes();
    step();
    check("t5_rst_grant", {28'd0, grant}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("t5_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    step();
    check("t5_rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    st = n_starts;
    er = n_err;
    tx_done = 1'b1;
    step();
    check("t5_done_ignored", {31'd0, busy}, 32'd0);
    repeat (80) step();
    check("t5_no_tx_start", n_starts - st, 32'd0);
    check("t5_no_err", n_err - er, 32'd0);

    // 6: tx_done in IDLE and in the tx_start cycle are both ignored
    tx_done = 1'b1;
    step();
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_grant", {28'd0, grant}, 32'd0);
    er = n_err;
    src_q[1].push_back({1'b1, 8'h3C});
    sb_q.push_back({4'b0010, 8'h3C});
    drive_lanes();
    wait_start(10, "t6_start_seen");
    tx_done = 1'b1;
    step();
    check("t6_wait_held", {31'd0, busy}, 32'd1);
    check("t6_grant_held", {28'd0, grant}, 32'd2);
    repeat (3) step();
    tx_done = 1'b1;
    step();
    check("t6_released", {31'd0, busy}, 32'd0);
    check("t6_grant_zero", {28'd0, grant}, 32'd0);
    check("t6_tx_data_holds", {24'd0, tx_data}, 32'h3C);
    check("t6_no_err", n_err - er, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
